// File: rtl/gpi_periph_if.sv
// ---------------------------------------------------------------------------
// gpi_periph_if
// CPU data-bus bundle for the general-purpose input peripheral.
//   address  : byte address from the CPU
//   data_in  : store data from the CPU
//   write    : store strobe
//   width    : byte-lane enables for stores
//   data_out : registered read data (zero when the block is not selected)
//   irq      : level interrupt
// master = CPU side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface gpi_periph_if;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic        write;
    logic [3:0]  width;
    logic [31:0] data_out;
    logic        irq;

    modport master (
        output address, data_in, write, width,
        input  data_out, irq
    );

    modport slave (
        input  address, data_in, write, width,
        output data_out, irq
    );
endinterface

// File: rtl/gpi_periph.sv
// ---------------------------------------------------------------------------
// gpi_periph
// Memory-mapped general-purpose input block. Synchronises WIDTH external
// pins, keeps sticky rising/falling edge flags and drives a maskable level
// interrupt. Read data is zero whenever the block is not addressed so it can
// be OR-ed onto the CPU read bus.
//
// Register map (offset = address[3:2]):
//   0x0 STATE    RO    debounced pin state
//   0x4 RISE     RW1C  sticky rising-edge flags
//   0x8 FALL     RW1C  sticky falling-edge flags
//   0xC IRQ_MASK RW    per-bit interrupt enable
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   pins  : asynchronous external inputs (WIDTH bits)
//   bus   : gpi_periph_if.slave (address, data_in, write, width,
//           data_out, irq)
//
// Optional feature: define GPI_DEBOUNCE_EN to add a per-bit debounce counter
// (DEBOUNCE_CYCLES stable cycles required before STATE changes). Without it
// STATE follows the second synchroniser flop directly.
// ---------------------------------------------------------------------------
module gpi_periph #(
    parameter int          WIDTH           = 8,
    parameter logic [9:0]  BASE_ADDR       = 10'h3E0,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins,
    gpi_periph_if.slave      bus
);

    logic             sel;
    logic [1:0]       offset;
    logic             wr_en;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] lane_bits;
    logic [WIDTH-1:0] wr_bits;

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] rise_reg;
    logic [WIDTH-1:0] fall_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] rise_ev;
    logic [WIDTH-1:0] fall_ev;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [31:0]      rd_val;
    logic [31:0]      data_out_reg;
    logic             irq_reg;
    logic [1:0]       arm_cnt_reg;
    logic             armed_reg;

    assign sel    = (bus.address[9:4] == BASE_ADDR[9:4]);
    assign offset = bus.address[3:2];
    assign wr_en  = sel && bus.write;

    // Expand the 4 byte-lane enables into a 32-bit bit mask.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_mask[gi*8 +: 8] = {8{bus.width[gi]}};
    end

    assign lane_bits = lane_mask[WIDTH-1:0];
    assign wr_bits   = bus.data_in[WIDTH-1:0] & lane_bits;
    assign rise_clr  = (wr_en && offset == 2'd1) ? wr_bits : '0;
    assign fall_clr  = (wr_en && offset == 2'd2) ? wr_bits : '0;

    // Arming: the first three edges after reset let the synchroniser fill
    // with the real pin levels so pins held high through reset do not
    // register as rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt_reg <= 2'd0;
            armed_reg   <= 1'b0;
        end else if (!armed_reg) begin
            if (arm_cnt_reg == 2'd2)
                armed_reg <= 1'b1;
            else
                arm_cnt_reg <= arm_cnt_reg + 2'd1;
        end
    end

`ifdef GPI_DEBOUNCE_EN
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        logic [CNT_W-1:0] cnt_reg;
        logic             differ;

        assign differ = sync2_reg[gi] ^ state_reg[gi];

        // The toggle happens on the edge where the counter already shows
        // DEBOUNCE_CYCLES-1 and the input still differs, i.e. after
        // DEBOUNCE_CYCLES consecutive differing cycles.
        assign state_next[gi] = !armed_reg                   ? sync2_reg[gi] :
                                (differ && cnt_reg == CNT_LAST) ? sync2_reg[gi] :
                                state_reg[gi];

        always_ff @(posedge clk) begin
            if (reset || !armed_reg || !differ)
                cnt_reg <= '0;
            else if (cnt_reg == CNT_LAST)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end
`else
    assign state_next = sync2_reg;
`endif

    assign rise_ev = state_next & ~state_reg & {WIDTH{armed_reg}};
    assign fall_ev = ~state_next & state_reg & {WIDTH{armed_reg}};

    always_comb begin
        rd_val = '0;
        case (offset)
            2'd0:    rd_val[WIDTH-1:0] = state_reg;
            2'd1:    rd_val[WIDTH-1:0] = rise_reg;
            2'd2:    rd_val[WIDTH-1:0] = fall_reg;
            default: rd_val[WIDTH-1:0] = mask_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            state_reg    <= '0;
            rise_reg     <= '0;
            fall_reg     <= '0;
            mask_reg     <= '0;
            data_out_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            sync1_reg <= pins;
            sync2_reg <= sync1_reg;
            state_reg <= state_next;
            // New events are OR-ed in after the clear so a simultaneous
            // event wins over a write-1-to-clear.
            rise_reg  <= (rise_reg & ~rise_clr) | rise_ev;
            fall_reg  <= (fall_reg & ~fall_clr) | fall_ev;
            if (wr_en && offset == 2'd3)
                mask_reg <= (mask_reg & ~lane_bits) | wr_bits;
            irq_reg      <= |((rise_reg | fall_reg) & mask_reg);
            data_out_reg <= (sel && !bus.write) ? rd_val : 32'd0;
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.irq      = irq_reg;

    // Address byte offset, upper data bits and upper lane bits carry no
    // meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{bus.address[1:0], bus.data_in, lane_mask,
                           (DEBOUNCE_CYCLES > 0)};

endmodule

// File: tb/tb_gpi_periph.sv
module tb_gpi_periph;

    localparam logic [9:0] IDLE  = 10'h000;
    localparam logic [9:0] A_ST  = 10'h3E0;
    localparam logic [9:0] A_RI  = 10'h3E4;
    localparam logic [9:0] A_FA  = 10'h3E8;
    localparam logic [9:0] A_MK  = 10'h3EC;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pins;
    int         checks = 0;
    int         failures = 0;

    gpi_periph_if bus_if ();

    gpi_periph #(
        .WIDTH(8),
        .BASE_ADDR(10'h3E0),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pins(pins),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pins;
        logic [9:0]  addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] p, input logic [9:0] a, input logic w,
                       input logic [3:0] be, input logic [31:0] d,
                       input logic [31:0] ed, input logic ei);
        vec_t v;
        v.pins = p; v.addr = a; v.wr = w; v.be = be; v.wdata = d;
        v.exp_dout = ed; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.address = IDLE;
        bus_if.write   = 1'b0;
        bus_if.width   = 4'h0;
        bus_if.data_in = 32'h0;
    endtask

    task automatic do_read(input string name, input logic [9:0] a, input logic [31:0] exp);
        bus_if.address = a;
        bus_if.write   = 1'b0;
        step();
        $display("read  %s addr=%h data_out=%h", name, a, bus_if.data_out);
        check(name, bus_if.data_out, exp);
        bus_idle();
    endtask

    task automatic do_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_if.address = a;
        bus_if.write   = 1'b1;
        bus_if.width   = be;
        bus_if.data_in = d;
        step();
        $display("write addr=%h be=%b data=%h", a, be, d);
        bus_idle();
    endtask

    task automatic do_reset(input logic [7:0] p);
        pins  = p;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        bus_idle();
        pins  = 8'hFF;
        reset = 1'b1;

        // Pins held high through reset: no spurious rising flag.
        step();
        step();
        check("rst_dout", bus_if.data_out, 32'h0);
        check("rst_irq", {31'h0, bus_if.irq}, 32'h0);
        reset = 1'b0;
        repeat (5) step();
        do_read("arm_state", A_ST, 32'h0000_00FF);
        do_read("arm_rise", A_RI, 32'h0);
        check("arm_irq", {31'h0, bus_if.irq}, 32'h0);

`ifndef GPI_DEBOUNCE_EN
        do_reset(8'h00);

        //   pins   addr  wr  be    wdata         exp_dout      irq
        add(8'h08, IDLE, 0, 4'h0, 32'h0,        32'h0,        0); // 0 sync1
        add(8'h08, A_ST, 0, 4'h0, 32'h0,        32'h0,        0); // 1 sync2
        add(8'h08, A_ST, 0, 4'h0, 32'h0,        32'h0,        0); // 2 state set
        add(8'h08, A_ST, 0, 4'h0, 32'h0,        32'h08,       0);
        add(8'h08, A_RI, 0, 4'h0, 32'h0,        32'h08,       0);
        add(8'h08, A_MK, 1, 4'hF, 32'h08,       32'h0,        0);
        add(8'h08, IDLE, 0, 4'h0, 32'h0,        32'h0,        1);
        add(8'h08, A_MK, 0, 4'h0, 32'h0,        32'h08,       1);
        add(8'h08, A_RI, 1, 4'hF, 32'h08,       32'h0,        1);
        add(8'h08, IDLE, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h08, A_RI, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h08, A_MK, 1, 4'h2, 32'h0000_00FF, 32'h0,       0); // lane 1 only
        add(8'h08, A_MK, 0, 4'h0, 32'h0,        32'h08,       0);
        add(8'h08, A_MK, 1, 4'h1, 32'h0000_FF00, 32'h0,       0); // lane 0 -> 0
        add(8'h08, A_MK, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h08, A_ST, 1, 4'hF, 32'hFF,       32'h0,        0); // RO
        add(8'h08, A_ST, 0, 4'h0, 32'h0,        32'h08,       0);
        add(8'h00, IDLE, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h00, IDLE, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h00, IDLE, 0, 4'h0, 32'h0,        32'h0,        0); // fall set
        add(8'h00, A_FA, 0, 4'h0, 32'h0,        32'h08,       0);
        add(8'h00, A_ST, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h00, A_MK, 1, 4'h1, 32'h08,       32'h0,        0);
        add(8'h00, IDLE, 0, 4'h0, 32'h0,        32'h0,        1);
        add(8'h00, A_FA, 1, 4'hF, 32'h0,        32'h0,        1); // 0 keeps
        add(8'h00, A_FA, 0, 4'h0, 32'h0,        32'h08,       1);
        add(8'h00, A_FA, 1, 4'h1, 32'h08,       32'h0,        1);
        add(8'h00, IDLE, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h00, A_FA, 0, 4'h0, 32'h0,        32'h0,        0);
        add(8'h00, 10'h3D0, 0, 4'h0, 32'h0,     32'h0,        0); // not selected
        add(8'h00, 10'h3F0, 0, 4'h0, 32'h0,     32'h0,        0);
        add(8'h00, 10'h1E0, 0, 4'h0, 32'h0,     32'h0,        0);
        add(8'h00, A_RI, 0, 4'h0, 32'h0,        32'h0,        0);

        for (int i = 0; i < vecs.size(); i++) begin
            pins           = vecs[i].pins;
            bus_if.address = vecs[i].addr;
            bus_if.write   = vecs[i].wr;
            bus_if.width   = vecs[i].be;
            bus_if.data_in = vecs[i].wdata;
            step();
            $display("vec %0d addr=%h wr=%b data_out=%h irq=%b", i,
                     vecs[i].addr, vecs[i].wr, bus_if.data_out, bus_if.irq);
            check($sformatf("vec%0d_dout", i), bus_if.data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_irq", i), {31'h0, bus_if.irq}, {31'h0, vecs[i].exp_irq});
        end
        bus_idle();

        // Rising event on bit 0 lands on the same edge as a W1C of bit 0.
        pins = 8'h01;
        step();
        step();
        do_write(A_RI, 4'hF, 32'h01);
        do_read("same_cycle_rise", A_RI, 32'h01);
        check("same_cycle_irq", {31'h0, bus_if.irq}, 32'h0);

        // Unmask everything, then reset while a read is pending.
        do_write(A_MK, 4'hF, 32'hFF);
        step();
        check("pre_rst_irq", {31'h0, bus_if.irq}, 32'h1);
        bus_if.address = A_RI;
        reset = 1'b1;
        step();
        check("rst_read_dout", bus_if.data_out, 32'h0);
        check("rst_read_irq", {31'h0, bus_if.irq}, 32'h0);
        bus_idle();
        step();
        reset = 1'b0;
        repeat (5) step();
        do_read("post_rst_state", A_ST, 32'h01);
        do_read("post_rst_rise", A_RI, 32'h0);
        do_read("post_rst_fall", A_FA, 32'h0);
        do_read("post_rst_mask", A_MK, 32'h0);
        check("post_rst_irq", {31'h0, bus_if.irq}, 32'h0);
`else
        do_reset(8'h00);

        // 10-cycle glitch on pin 1 is rejected.
        pins = 8'h02;
        repeat (10) step();
        pins = 8'h00;
        repeat (30) step();
        do_read("glitch_state", A_ST, 32'h0);
        do_read("glitch_rise", A_RI, 32'h0);
        do_read("glitch_fall", A_FA, 32'h0);

        // Sustained level: sync2 changes on edge 2, state on edge 18.
        pins = 8'h02;
        repeat (17) step();
        do_read("db_state_early", A_ST, 32'h0);
        do_read("db_state_set", A_ST, 32'h02);
        do_read("db_rise", A_RI, 32'h02);
        do_write(A_RI, 4'hF, 32'h02);

        // Reset while the pin 2 counter sits at 10.
        pins = 8'h06;
        repeat (12) step();
        bus_if.address = A_ST;
        reset = 1'b1;
        step();
        check("db_rst_dout", bus_if.data_out, 32'h0);
        check("db_rst_irq", {31'h0, bus_if.irq}, 32'h0);
        bus_idle();
        reset = 1'b0;
        repeat (5) step();
        do_read("db_post_rise", A_RI, 32'h0);
        do_read("db_post_fall", A_FA, 32'h0);
        do_read("db_post_state", A_ST, 32'h06);
        do_read("db_post_mask", A_MK, 32'h0);
        check("db_post_irq", {31'h0, bus_if.irq}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpi_periph.md
Name: gpi_periph

Overview:
- Memory-mapped general-purpose input peripheral; the input-direction counterpart of the LED output peripheral.
- Samples WIDTH asynchronous input pins and synchronises them, with optional debouncing.
- Captures sticky rising/falling edge flags and raises a maskable interrupt line.
- Sits on the CPU data bus beside data memory and the LED peripheral. Its read data is OR-combined into the CPU data_in, so its output is zero whenever it is not selected.

Parameters:
- WIDTH, 8, number of input pins (1..32).
- BASE_ADDR, 10'h3E0, byte address of the register block; 16-byte aligned; decode compares address[9:4].
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced state changes (used only with GPI_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  10  CPU data byte address.
- data_in  in  32  CPU write data.
- write  in  1  CPU store strobe.
- width  in  4  byte-lane enable mask for stores.
- pins  in  WIDTH  asynchronous external inputs.
- data_out  out  32  registered read data; zero when not selected.
- irq  out  1  level interrupt.

Behaviour:
- sel = (address[9:4] == BASE_ADDR[9:4]). Register offset = address[3:2].
- Register map. Unused upper bits read 0.
  - 0x0 STATE (RO): debounced pin state.
  - 0x4 RISE (RW1C): sticky rising-edge flags.
  - 0x8 FALL (RW1C): sticky falling-edge flags.
  - 0xC IRQ_MASK (RW): per-bit interrupt enable.
- Input path:
  - 2-flop synchroniser per bit (sync1, sync2).
  - Without debounce, state <= sync2 every cycle.
- Edge detection:
  - rise_ev = state_next & ~state; fall_ev = ~state_next & state.
  - Flags are set on the same edge the state register updates.
- Latency, no debounce: a pin change sampled into sync1 at edge N reaches sync2 at N+1, and state plus its flag at N+2.
- Reads:
  - data_out is registered: at edge K, if sel && !write, data_out <= selected register value (pre-update value at edge K); otherwise data_out <= 0.
  - Read data is therefore valid for exactly one cycle, the cycle after the address was presented.
- Reads have no side effects.
- Writes (sel && write):
  - Bit i is affected only if width[i/8] is set.
  - RISE/FALL: a 1 written clears that flag; a 0 leaves it.
  - IRQ_MASK: loaded per enabled lane.
  - STATE: writes ignored.
- A set event and a W1C on the same bit in the same cycle: the set wins (flag stays 1).
- irq is registered: irq <= |((RISE | FALL) & IRQ_MASK). It lags the flag/mask change by one cycle.
- Reset:
  - Clears sync1, sync2, state, RISE, FALL, IRQ_MASK, debounce counters, data_out, irq.
  - Clears the armed bit.
- Armed bit:
  - While armed=0, state tracks sync2 directly and no edge flags are set.
  - armed sets 3 cycles after reset deasserts, so pins held high through reset produce no spurious RISE.
- Reset asserted mid-debounce or mid-read: all of the above is cleared on that edge. A pending read returns 0.

Optional Feature:
- Macro GPI_DEBOUNCE_EN.
- Defined:
  - Per-bit counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears when sync2[i] == state[i]; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync2[i] != state[i] that cycle, state[i] toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- Undefined: no counters. state follows sync2 with the latency given above. DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset with pins=8'hFF held, release reset, wait 5 cycles, read 0x0 then 0x4 -> STATE=0x000000FF, RISE=0, irq=0.
- No debounce: pins[3] 0->1 at edge N -> STATE bit3=1 and RISE=0x08 at edge N+2. Write 0xC=0x08 -> irq=1 one cycle later. Write 0x4=0x08 -> RISE=0, irq=0 next cycle.
- Same cycle: pins[0] rising event and W1C of RISE bit0 -> RISE bit0 reads 1 afterwards.
- Write 0xC data 0x0000FF00 with width=4'b0001 -> IRQ_MASK unchanged (0). Read at address outside BASE_ADDR block -> data_out=0 every cycle.
- With GPI_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - 10-cycle pulse on pins[1] -> STATE unchanged, FALL/RISE=0.
  - 20-cycle level on pins[1] -> STATE bit1 set exactly 16 cycles after sync2 changes, RISE=0x02.
- Assert reset while the pins[2] debounce counter is at 10 -> all registers 0, data_out=0, irq=0 the next cycle, no flag after release.
